// File: rtl/mips_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_pkg
// Brief    : Shared state encodings, opcode constants and control codes for
//            the multi-cycle MIPS control unit.
// Revision : 1.0  initial release
// ============================================================================
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_EXEC_I    = 4'd11,
        S_I_WB      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14
    } state_e;

    // Instruction classes produced by the opcode classifier
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_JR      = 3'd1,
        CLS_MEM     = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_IMM     = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_JAL     = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_LUI   = 3'd5;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
    localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
    localparam logic [1:0] MEMTOREG_PC     = 2'd2;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control_if
// Brief    : Control <-> datapath bundle: instruction fields, ALU flag and
//            memory handshake in, mux selects and write enables out.
// Revision : 1.0  initial release
// ============================================================================
interface mips_multicycle_control_if;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state_dbg;

    // Control unit side
    modport master (
        input  OP, Funct, Zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
               illegal_op, state_dbg
    );

    // Datapath side
    modport slave (
        output OP, Funct, Zero, mem_ready,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
               illegal_op, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mips_mc_opdecode.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_opdecode
// Brief    : Combinational OP/Funct classifier; yields the instruction class
//            and the ALU operation used by immediate-format instructions.
// Revision : 1.0  initial release
// ============================================================================
module mips_mc_opdecode
    import mips_mc_pkg::*;
(
    input  logic [5:0]   i_op,
    input  logic [5:0]   i_funct,
    output instr_class_e o_instr_class,
    output logic [2:0]   o_imm_aluop
);

    // Map opcode (and funct for the special opcode) onto an instruction class
    always_comb begin
        o_instr_class = CLS_ILLEGAL;
        o_imm_aluop   = ALU_ADD;
        case (i_op)
            OP_RTYPE: o_instr_class = (i_funct == FUNCT_JR) ? CLS_JR : CLS_RTYPE;
            OP_LW,
            OP_SW:    o_instr_class = CLS_MEM;
            OP_BEQ,
            OP_BNE:   o_instr_class = CLS_BRANCH;
            OP_ADDI:  begin o_instr_class = CLS_IMM; o_imm_aluop = ALU_ADD; end
            OP_ANDI:  begin o_instr_class = CLS_IMM; o_imm_aluop = ALU_AND; end
            OP_ORI:   begin o_instr_class = CLS_IMM; o_imm_aluop = ALU_OR;  end
            OP_LUI:   begin o_instr_class = CLS_IMM; o_imm_aluop = ALU_LUI; end
            OP_J:     o_instr_class = CLS_JUMP;
            OP_JAL:   o_instr_class = CLS_JAL;
            default:  o_instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Brief    : Moore control FSM sequencing a multi-cycle MIPS datapath with a
//            shared memory and a single ALU; stalls on mem_ready.
// Revision : 1.0  initial release
// ============================================================================
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_multicycle_control_if.master   bus
);

    localparam logic [3:0] INIT_LAST = 4'(RESET_PC_HOLD - 1);

    state_e       state_q, state_d;
    logic [3:0]   init_cnt_q, init_cnt_d;
    instr_class_e w_instr_class;
    logic [2:0]   w_imm_aluop;

    mips_mc_opdecode u_opdecode (
        .i_op          (bus.OP),
        .i_funct       (bus.Funct),
        .o_instr_class (w_instr_class),
        .o_imm_aluop   (w_imm_aluop)
    );

    // Next-state selection, including the post-reset hold counter
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = S_FETCH;
                    init_cnt_d = 4'd0;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (w_instr_class)
                    CLS_RTYPE:  state_d = S_EXEC_R;
                    CLS_JR:     state_d = S_JR;
                    CLS_MEM:    state_d = S_MEM_ADDR;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_IMM:    state_d = S_EXEC_I;
                    CLS_JUMP:   state_d = S_JUMP;
                    CLS_JAL:    state_d = S_JAL;
                    default:    state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.OP == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC_R:    state_d = S_R_WB;
            S_EXEC_I:    state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH,
            S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            default:     state_d = S_INIT;
        endcase
    end

    // State register; reset drops straight into INIT so no enable can fire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Per-state datapath controls; the stall-dependent enables follow mem_ready
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = REGDST_RT;
        bus.MemtoReg   = MEMTOREG_ALUOUT;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = SRCB_RT;
        bus.ALUOp      = ALU_ADD;
        bus.PCSource   = PCSRC_ALU;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                bus.ALUSrcB = SRCB_FOUR;
            end
            S_DECODE: begin
                // Branch target lands in ALUOut ahead of the BRANCH state
                bus.ALUSrcB    = SRCB_IMM_SH2;
                bus.illegal_op = (w_instr_class == CLS_ILLEGAL);
                bus.instr_done = (w_instr_class == CLS_ILLEGAL);
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEM_WB: begin
                bus.RegWrite   = 1'b1;
                bus.MemtoReg   = MEMTOREG_MDR;
                bus.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.MemWrite   = 1'b1;
                bus.IorD       = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNCT;
            end
            S_R_WB: begin
                bus.RegWrite   = 1'b1;
                bus.RegDst     = REGDST_RD;
                bus.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOp   = w_imm_aluop;
            end
            S_I_WB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUOp      = ALU_SUB;
                bus.PCSource   = PCSRC_ALUOUT;
                bus.PCWrite    = (bus.OP == OP_BEQ) ? bus.Zero : ~bus.Zero;
                bus.instr_done = 1'b1;
            end
            S_JUMP: begin
                bus.PCSource   = PCSRC_JUMP;
                bus.PCWrite    = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4, so it is the link value
                bus.PCSource   = PCSRC_JUMP;
                bus.PCWrite    = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.RegDst     = REGDST_RA;
                bus.MemtoReg   = MEMTOREG_PC;
                bus.instr_done = 1'b1;
            end
            S_JR: begin
                bus.PCSource   = PCSRC_RS;
                bus.PCWrite    = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mips_multicycle_control
// Brief    : Self-checking bench: reference vectors, directed corner cases and
//            random instruction streams against an instruction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_control;

    localparam int K_R = 0, K_JR = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                   K_IMM = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_control_if bus();

    mips_multicycle_control #(.RESET_PC_HOLD(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Captured per-cycle controls of the most recent instruction
    logic       s_a    [64];
    logic [1:0] s_b    [64];
    logic [2:0] s_aluop[64];
    logic       s_pcw  [64];
    logic [1:0] s_pcs  [64];
    int         last_lat;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zb;
        int         lat;
        logic       a;
        logic [1:0] b;
        logic [2:0] aluop;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] all_outs();
        return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUOp, bus.PCSource, bus.instr_done, bus.illegal_op};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                      return (fn == 6'h08) ? K_JR : K_R;
            6'h23:                      return K_LW;
            6'h2B:                      return K_SW;
            6'h04, 6'h05:               return K_BR;
            6'h08, 6'h0C, 6'h0D, 6'h0F: return K_IMM;
            6'h02:                      return K_J;
            6'h03:                      return K_JAL;
            default:                    return K_ILL;
        endcase
    endfunction

    // Runs one instruction from FETCH: nf fetch-stall cycles, nm data-stall
    // cycles; with rnd set, mem_ready/Zero are random where they are don't-care.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zb,
                             input int nf, input int nm, input bit rnd, input string tag);
        int k, data_idx, cyc, expv;
        int exp_st[$];
        bit is_mem, taken, done, viol, fetch_bad, dec_bad;
        int e_rw, e_rd, e_m2r, e_pcw, e_pcs, e_mr, e_mw, e_iord;
        int c_rw, c_pcw, c_mr, c_mw, c_iord, c_ir, c_ill, l_rd, l_m2r, l_pcs;
        logic mr;
        k        = classify(op, fn);
        is_mem   = (k == K_LW) || (k == K_SW);
        taken    = (op == 6'h04) ? zb : !zb;
        data_idx = nf + 3;
        for (int i = 0; i <= nf; i++) exp_st.push_back(1);
        exp_st.push_back(2);
        case (k)
            K_R:   begin exp_st.push_back(7); exp_st.push_back(8); end
            K_JR:  exp_st.push_back(14);
            K_LW:  begin
                exp_st.push_back(3);
                for (int i = 0; i <= nm; i++) exp_st.push_back(4);
                exp_st.push_back(5);
            end
            K_SW:  begin
                exp_st.push_back(3);
                for (int i = 0; i <= nm; i++) exp_st.push_back(6);
            end
            K_BR:  exp_st.push_back(9);
            K_IMM: begin exp_st.push_back(11); exp_st.push_back(12); end
            K_J:   exp_st.push_back(10);
            K_JAL: exp_st.push_back(13);
            default: ;
        endcase
        e_rw   = (k == K_R || k == K_LW || k == K_IMM || k == K_JAL) ? 1 : 0;
        e_rd   = (k == K_R) ? 1 : (k == K_JAL) ? 2 : 0;
        e_m2r  = (k == K_LW) ? 1 : (k == K_JAL) ? 2 : 0;
        e_pcw  = 1;
        e_pcs  = 0;
        if (k == K_BR && taken) begin e_pcw = 2; e_pcs = 1; end
        if (k == K_J || k == K_JAL) begin e_pcw = 2; e_pcs = 2; end
        if (k == K_JR) begin e_pcw = 2; e_pcs = 3; end
        e_mr   = nf + 1 + ((k == K_LW) ? nm + 1 : 0);
        e_mw   = (k == K_SW) ? nm + 1 : 0;
        e_iord = is_mem ? nm + 1 : 0;

        {c_rw, c_pcw, c_mr, c_mw, c_iord, c_ir, c_ill, l_rd, l_m2r, l_pcs} = '0;
        {done, viol, fetch_bad, dec_bad} = '0;
        cyc = 0;
        while (!done && cyc < 64) begin
            bus.OP    = op;
            bus.Funct = fn;
            if (cyc < nf)                                         mr = 1'b0;
            else if (cyc == nf)                                   mr = 1'b1;
            else if (is_mem && cyc >= data_idx && cyc < data_idx + nm) mr = 1'b0;
            else if (is_mem && cyc == data_idx + nm)              mr = 1'b1;
            else mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.mem_ready = mr;
            bus.Zero = (cyc == nf + 2) ? zb : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            @(negedge clk);
            expv = (cyc < exp_st.size()) ? exp_st[cyc] : 15;
            check($sformatf("%s state c%0d", tag, cyc), {28'd0, bus.state_dbg}, expv);
            s_a[cyc] = bus.ALUSrcA; s_b[cyc] = bus.ALUSrcB; s_aluop[cyc] = bus.ALUOp;
            s_pcw[cyc] = bus.PCWrite; s_pcs[cyc] = bus.PCSource;
            if (bus.RegWrite) begin c_rw++; l_rd = bus.RegDst; l_m2r = bus.MemtoReg; end
            if (bus.PCWrite)  begin c_pcw++; l_pcs = bus.PCSource; end
            if (bus.MemRead)    c_mr++;
            if (bus.MemWrite)   c_mw++;
            if (bus.IorD)       c_iord++;
            if (bus.IRWrite)    c_ir++;
            if (bus.illegal_op) c_ill++;
            if (bus.MemRead && bus.MemWrite) viol = 1'b1;
            if (bus.PCWrite && bus.IRWrite && bus.state_dbg != 4'd1) viol = 1'b1;
            if (cyc <= nf && (bus.ALUSrcA !== 1'b0 || bus.ALUSrcB !== 2'd1 ||
                bus.ALUOp !== 3'd0 || bus.PCSource !== 2'd0 || bus.IorD !== 1'b0))
                fetch_bad = 1'b1;
            if (cyc == nf + 1 && (bus.ALUSrcA !== 1'b0 || bus.ALUSrcB !== 2'd3 ||
                bus.ALUOp !== 3'd0))
                dec_bad = 1'b1;
            if (bus.instr_done) done = 1'b1;
            cyc++;
            @(posedge clk);
            #1;
        end
        last_lat = cyc;
        check({tag, " done seen"}, {31'd0, done}, 1);
        check({tag, " latency"}, cyc, exp_st.size());
        check({tag, " regwrite cnt"}, c_rw, e_rw);
        if (e_rw != 0) begin
            check({tag, " regdst"}, l_rd, e_rd);
            check({tag, " memtoreg"}, l_m2r, e_m2r);
        end
        check({tag, " pcwrite cnt"}, c_pcw, e_pcw);
        check({tag, " pcsource"}, l_pcs, e_pcs);
        check({tag, " memread cyc"}, c_mr, e_mr);
        check({tag, " memwrite cyc"}, c_mw, e_mw);
        check({tag, " iord cyc"}, c_iord, e_iord);
        check({tag, " irwrite cnt"}, c_ir, 1);
        check({tag, " illegal cnt"}, c_ill, (k == K_ILL) ? 1 : 0);
        check({tag, " exclusivity"}, {31'd0, viol}, 0);
        check({tag, " fetch ctl"}, {31'd0, fetch_bad}, 0);
        check({tag, " decode ctl"}, {31'd0, dec_bad}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[12];
        logic [5:0] ops[13];
        logic [5:0] rop, rfn;
        int         idx;

        tbl[0]  = '{6'h00, 6'h20, 1'b0, 4, 1'b1, 2'd0, 3'd2};
        tbl[1]  = '{6'h23, 6'h00, 1'b0, 5, 1'b1, 2'd2, 3'd0};
        tbl[2]  = '{6'h2B, 6'h00, 1'b0, 4, 1'b1, 2'd2, 3'd0};
        tbl[3]  = '{6'h04, 6'h00, 1'b1, 3, 1'b1, 2'd0, 3'd1};
        tbl[4]  = '{6'h05, 6'h00, 1'b0, 3, 1'b1, 2'd0, 3'd1};
        tbl[5]  = '{6'h08, 6'h00, 1'b0, 4, 1'b1, 2'd2, 3'd0};
        tbl[6]  = '{6'h0C, 6'h00, 1'b0, 4, 1'b1, 2'd2, 3'd4};
        tbl[7]  = '{6'h0D, 6'h00, 1'b0, 4, 1'b1, 2'd2, 3'd3};
        tbl[8]  = '{6'h0F, 6'h00, 1'b0, 4, 1'b1, 2'd2, 3'd5};
        tbl[9]  = '{6'h02, 6'h00, 1'b0, 3, 1'b0, 2'd0, 3'd0};
        tbl[10] = '{6'h03, 6'h00, 1'b0, 3, 1'b0, 2'd0, 3'd0};
        tbl[11] = '{6'h00, 6'h08, 1'b0, 3, 1'b0, 2'd0, 3'd0};
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C,
                6'h0D, 6'h0F, 6'h02, 6'h03, 6'h00, 6'h3F};

        // Reset and INIT hold
        reset = 1'b1;
        bus.OP = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", {28'd0, bus.state_dbg}, 0);
        check("reset outputs", {12'd0, all_outs()}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("init state", {28'd0, bus.state_dbg}, 0);
        check("init outputs", {12'd0, all_outs()}, 0);
        @(posedge clk);
        #1;
        check("fetch after init", {28'd0, bus.state_dbg}, 1);

        // Reference vectors, no stalls
        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].zb, 0, 0, 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table latency", i), last_lat, tbl[i].lat);
            check($sformatf("vec%0d ALUSrcA", i), {31'd0, s_a[2]}, {31'd0, tbl[i].a});
            check($sformatf("vec%0d ALUSrcB", i), {30'd0, s_b[2]}, {30'd0, tbl[i].b});
            check($sformatf("vec%0d ALUOp", i), {29'd0, s_aluop[2]}, {29'd0, tbl[i].aluop});
        end

        // bne not taken then taken
        run_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b0, "bne z1");
        check("bne z1 pcwrite c3", {31'd0, s_pcw[2]}, 0);
        run_instr(6'h05, 6'h00, 1'b0, 0, 0, 1'b0, "bne z0");
        check("bne z0 pcwrite c3", {31'd0, s_pcw[2]}, 1);
        check("bne z0 pcsource c3", {30'd0, s_pcs[2]}, 1);

        // lw with a three-cycle memory stall
        run_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0, "lw stall");
        check("lw stall total", last_lat, 8);

        // jal, jr, illegal, and a stalled fetch
        run_instr(6'h03, 6'h00, 1'b0, 0, 0, 1'b0, "jal");
        check("jal total", last_lat, 3);
        run_instr(6'h00, 6'h08, 1'b0, 0, 0, 1'b0, "jr");
        check("jr pcsource c3", {30'd0, s_pcs[2]}, 3);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0, "illegal");
        check("illegal total", last_lat, 2);
        run_instr(6'h2B, 6'h00, 1'b0, 2, 2, 1'b0, "sw stalls");

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            idx = $urandom_range(0, 13);
            rop = (idx == 13) ? 6'($urandom_range(0, 63)) : ops[idx];
            rfn = ($urandom_range(0, 7) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
            run_instr(rop, rfn, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b1, $sformatf("rnd%0d op%0h", n, rop));
        end

        // Reset in the middle of a stalled MEM_READ
        bus.OP = 6'h23; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        #1;
        check("pre-reset in MEM_READ", {28'd0, bus.state_dbg}, 4);
        check("pre-reset MemRead", {31'd0, bus.MemRead}, 1);
        reset = 1'b1;
        #1;
        check("async reset state", {28'd0, bus.state_dbg}, 0);
        check("async reset outputs", {12'd0, all_outs()}, 0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("post reset init", {28'd0, bus.state_dbg}, 0);
        check("post reset outputs", {12'd0, all_outs()}, 0);
        @(posedge clk);
        #1;
        check("post reset fetch", {28'd0, bus.state_dbg}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Moore-style control state machine that sequences a multi-cycle version of the MIPS datapath: shared instruction/data memory, instruction register, single ALU reused for PC+4 and branch target. It replaces the single-cycle combinational control and the branch AND/OR gating. It takes the opcode, funct and ALU Zero, and drives every datapath mux select and write enable per cycle. It stalls on a memory-ready handshake.

Parameters:
RESET_PC_HOLD, 1, number of INIT cycles after reset release before the first FETCH (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
OP  in  6  instruction [31:26] from the instruction register
Funct  in  6  instruction [5:0]
Zero  in  1  ALU zero flag, valid in the BRANCH state
mem_ready  in  1  memory completes the access this cycle
PCWrite  out  1  PC load enable, with branch condition already resolved
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
RegDst  out  2  write register select: 0 = rt, 1 = rd, 2 = $31
MemtoReg  out  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  0 = rt, 1 = const 4, 2 = signext imm, 3 = signext imm << 2
ALUOp  out  3  0 = add, 1 = sub, 2 = funct, 3 = or, 4 = and, 5 = lui
PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
state_dbg  out  4  current state encoding

Behaviour:
- States (4-bit encoding): INIT=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, R_WB=8, BRANCH=9, JUMP=10, EXEC_I=11, I_WB=12, JAL=13, JR=14.
- Reset (asynchronous): state = INIT, INIT counter = 0.
  - In INIT every output is 0, including ALUOp, PCSource and instr_done; state_dbg = 0.
  - INIT lasts RESET_PC_HOLD cycles after reset falls, then goes to FETCH.
  - Reset asserted in any state returns immediately to INIT; no write enable may be high in the cycle reset is seen.
- FETCH: MemRead=1, IorD=0, IRWrite=mem_ready, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSource=0, PCWrite=mem_ready. Holds while mem_ready=0; IRWrite and PCWrite stay low during the stall. Moves to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=add (branch target precomputed into ALUOut). Next state by OP:
  - 0x00 with Funct 0x08 -> JR; other 0x00 -> EXEC_R
  - 0x23, 0x2B -> MEM_ADDR
  - 0x04, 0x05 -> BRANCH
  - 0x08, 0x0C, 0x0D, 0x0F -> EXEC_I
  - 0x02 -> JUMP; 0x03 -> JAL
  - anything else -> FETCH, with illegal_op=1 and instr_done=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, add. Goes to MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: MemRead=1, IorD=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until mem_ready; instr_done=mem_ready -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=funct -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2. ALUOp = add for 0x08, and for 0x0C, or for 0x0D, lui for 0x0F -> I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCSource=1. PCWrite = Zero for beq, ~Zero for bne. instr_done=1 -> FETCH.
- JUMP: PCSource=2, PCWrite=1, instr_done=1 -> FETCH.
- JAL: PCSource=2, PCWrite=1, RegWrite=1, RegDst=2, MemtoReg=2 (PC already holds PC+4), instr_done=1 -> FETCH.
- JR: PCSource=3, PCWrite=1, instr_done=1 -> FETCH.
- Any output not listed for a state is 0.
- Latency with mem_ready held at 1: R-type 4, lw 5, sw 4, addi/andi/ori/lui 4, beq/bne 3, j/jal/jr 3 cycles. Each cycle mem_ready is low adds one cycle.
- MemRead and MemWrite are never both high. PCWrite and IRWrite are high together only in FETCH.

Decomposition:
- Package mips_mc_pkg holds:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_J, OP_JAL, and FUNCT_JR
  - ALUOp, PCSource, RegDst and MemtoReg codes
- One sub-module, mips_mc_opdecode: combinational OP/Funct classifier giving the instruction class and the immediate ALUOp. The FSM uses it for the DECODE transition and in EXEC_I.

Test Plan:
- Reset mid-MEM_READ, then release with RESET_PC_HOLD=1 -> all outputs 0 and state_dbg=0 within the reset cycle; FETCH (state_dbg=1) exactly 1 cycle after reset falls.
- OP=0x00, Funct=0x20, mem_ready=1 -> states 1,2,7,8; RegWrite=1 and RegDst=1 only in cycle 4; instr_done pulses once.
- OP=0x23, with mem_ready low for 3 cycles in MEM_READ -> 8 cycles total; MemRead=1 and IorD=1 throughout the stall; RegWrite=1 with MemtoReg=1 once.
- OP=0x05 with Zero=1, then with Zero=0 -> PCWrite=0, then PCWrite=1 with PCSource=1, in the 3rd cycle.
- OP=0x03 -> JAL state: PCWrite=1, RegWrite=1, RegDst=2, MemtoReg=2; 3 cycles. OP=0x00 with Funct=0x08 -> PCSource=3.
- OP=0x3F -> illegal_op=1 and instr_done=1 in DECODE, next state FETCH; no write enable is asserted.
